// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: synchronizes and debounces a raw button, emitting press/release/auto-repeat pulses
module btn_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_RATE     = 100000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic en_pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
  localparam logic IDLE_RAW = (BTN_ACTIVE_LOW != 0);
  localparam logic RPT = (REPEAT_EN != 0);
  localparam logic [1:0] RELEASED    = 2'd0;
  localparam logic [1:0] HELD_DELAY  = 2'd1;
  localparam logic [1:0] HELD_REPEAT = 2'd2;
  logic sync1_q, sync2_q, s_sync;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d, thr;
  logic [1:0] state_q, state_d;
  logic level_q, level_d, flip, held, tick;
  logic press_q, press_d, release_q, release_d, repeat_q, repeat_d, en_q, en_d;
  always_comb begin
    s_sync    = sync2_q ^ IDLE_RAW;
    flip      = (s_sync != level_q) && (dcnt_q == DW'(DEBOUNCE_CYCLES - 1));
    dcnt_d    = (s_sync == level_q || flip) ? '0 : dcnt_q + DW'(1);
    level_d   = level_q ^ flip;
    press_d   = flip && !level_q;
    release_d = flip && level_q;
    held      = state_q != RELEASED;
    thr       = state_q == HELD_DELAY ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1);
    tick      = RPT && held && !release_d && (rcnt_q == thr);
    repeat_d  = tick;
    en_d      = press_d || tick;
    state_d   = release_d ? RELEASED : press_d ? HELD_DELAY : tick ? HELD_REPEAT : state_q;
    rcnt_d    = (release_d || press_d || tick) ? '0 : (RPT && held) ? rcnt_q + RW'(1) : rcnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= IDLE_RAW;
      sync2_q   <= IDLE_RAW;
      dcnt_q    <= '0;
      rcnt_q    <= '0;
      state_q   <= RELEASED;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      dcnt_q    <= dcnt_d;
      rcnt_q    <= rcnt_d;
      state_q   <= state_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      en_q      <= en_d;
    end
  end
  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign en_pulse      = en_q;
endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb_btn_pulse_gen: scoreboard bench checking pulse timing against hand-computed edge numbers
module tb_btn_pulse_gen;
  logic clk, reset, btn_in;
  logic btn_level, press_pulse, release_pulse, repeat_pulse, en_pulse;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic prev_en = 1'b0;
  typedef struct {
    int cyc;
    logic [4:0] v;
  } ev_t;
  ev_t sb[$];
  btn_pulse_gen #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_EN(1),
    .REPEAT_DELAY(20),
    .REPEAT_RATE(8),
    .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse),
    .en_pulse(en_pulse)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void exp_ev(input int c, input logic pr, input logic rl, input logic rp);
    ev_t e;
    e.cyc = c;
    e.v = {pr | rp, pr, rl, rp, pr | rp};
    sb.push_back(e);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
    end
  endtask
  task automatic go(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic set_btn(input logic v, output int n);
    btn_in = v;
    n = cyc + 1;
  endtask
  initial begin
    ev_t e;
    logic [4:0] act;
    forever begin
      @(posedge clk);
      #1;
      act = {btn_level, press_pulse, release_pulse, repeat_pulse, en_pulse};
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        total++;
        bad++;
        $display("FAIL missed_event: expected %b at edge %0d, absent at edge %0d", e.v, e.cyc, cyc);
      end
      if (press_pulse || release_pulse || repeat_pulse || en_pulse) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse: got %b at edge %0d, expected none", act, cyc);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.v !== act) begin
            bad++;
            $display("FAIL event: got %b at edge %0d, expected %b at edge %0d", act, cyc, e.v, e.cyc);
          end
        end
      end
      if (en_pulse) begin
        total++;
        if (prev_en) begin
          bad++;
          $display("FAIL en_back_to_back: got en high at edges %0d and %0d, expected isolated", cyc - 1, cyc);
        end
      end
      prev_en = en_pulse;
    end
  end
  initial begin
    int n, p;
    reset = 1'b1;
    btn_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("reset_outputs", 32'({btn_level, press_pulse, release_pulse, repeat_pulse, en_pulse}), 32'd0);
    reset = 1'b0;
    go(15);
    chk("idle_level", 32'(btn_level), 32'd0);
    set_btn(1'b0, n);
    p = n + 5;
    exp_ev(p, 1, 0, 0);
    go(p + 1);
    chk("press_level", 32'(btn_level), 32'd1);
    chk("press_one_cycle", 32'(press_pulse), 32'd0);
    go(p + 10);
    set_btn(1'b1, n);
    exp_ev(n + 5, 0, 1, 0);
    go(n + 8);
    chk("release_level", 32'(btn_level), 32'd0);
    for (int i = 0; i < 10; i++) begin
      btn_in = i[0];
      repeat (2) @(negedge clk);
    end
    chk("bounce_level", 32'(btn_level), 32'd0);
    set_btn(1'b0, n);
    p = n + 5;
    exp_ev(p, 1, 0, 0);
    for (int k = 0; k < 5; k++) exp_ev(p + 20 + 8 * k, 0, 0, 1);
    go(p + 52);
    set_btn(1'b1, n);
    exp_ev(n + 5, 0, 1, 0);
    go(n + 8);
    set_btn(1'b0, n);
    p = n + 5;
    exp_ev(p, 1, 0, 0);
    exp_ev(p + 20, 0, 0, 1);
    go(p + 22);
    set_btn(1'b1, n);
    exp_ev(n + 5, 0, 1, 0);
    go(n + 5);
    chk("coincident_release", 32'({release_pulse, repeat_pulse}), 32'b10);
    go(n + 8);
    set_btn(1'b0, n);
    p = n + 5;
    exp_ev(p, 1, 0, 0);
    go(p + 10);
    reset = 1'b1;
    go(p + 11);
    chk("mid_reset_outputs", 32'({btn_level, press_pulse, release_pulse, repeat_pulse, en_pulse}), 32'd0);
    go(p + 13);
    reset = 1'b0;
    p = p + 19;
    exp_ev(p, 1, 0, 0);
    for (int k = 0; k < 3; k++) exp_ev(p + 20 + 8 * k, 0, 0, 1);
    go(p + 32);
    set_btn(1'b1, n);
    exp_ev(n + 5, 0, 1, 0);
    go(n + 12);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("final_level", 32'(btn_level), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
